// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: shares one UART transmitter between NUM_REQ byte requesters.
//   clk, reset   : system clock, asynchronous active-high reset
//   req_valid    : per-requester byte-available flags
//   req_data     : packed requester bytes, requester i in [i*DATA_WIDTH +: DATA_WIDTH]
//   req_ready    : one-hot, one-cycle accept pulse
//   tx_start     : one-cycle start strobe to the transmitter
//   tx_data      : latched byte, stable from tx_start until the arbiter is idle again
//   tx_busy      : transmitter busy, high for the whole frame
//   grant_id     : requester owning the current/last transfer
//   arb_busy     : high whenever the FSM is not IDLE
//   timeout_err  : sticky, set when tx_busy fails to rise after tx_start
// Define UART_TX_ARB_FIXED_PRIORITY_EN for fixed priority (requester 0 highest)
// instead of round robin.
module uart_tx_arbiter #(
   parameter int NUM_REQ = 2,
   parameter int DATA_WIDTH = 8,
   parameter int START_TIMEOUT = 16,
   localparam int IW = NUM_REQ > 1 ? $clog2(NUM_REQ) : 1
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic [NUM_REQ-1:0]            req_valid,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
   output logic [NUM_REQ-1:0]            req_ready,
   output logic                          tx_start,
   output logic [DATA_WIDTH-1:0]         tx_data,
   input  logic                          tx_busy,
   output logic [IW-1:0]                 grant_id,
   output logic                          arb_busy,
   output logic                          timeout_err
);
   localparam int CW = START_TIMEOUT > 1 ? $clog2(START_TIMEOUT) : 1;
   localparam logic [2:0] IDLE = 3'd0;
   localparam logic [2:0] LOAD = 3'd1;
   localparam logic [2:0] START = 3'd2;
   localparam logic [2:0] WAIT_BUSY = 3'd3;
   localparam logic [2:0] WAIT_DONE = 3'd4;

   logic [2:0]            state_q, state_d;
   logic [NUM_REQ-1:0]    req_ready_q, req_ready_d;
   logic                  tx_start_q, tx_start_d;
   logic [DATA_WIDTH-1:0] tx_data_q, tx_data_d;
   logic [IW-1:0]         grant_id_q, grant_id_d;
   logic [CW-1:0]         cnt_q, cnt_d;
   logic                  timeout_err_q, timeout_err_d;
   logic [IW-1:0]         base, win;

   // Scan from the highest offset down so the last hit is the first set bit at/after b.
   function automatic logic [IW-1:0] pick(input logic [NUM_REQ-1:0] v, input logic [IW-1:0] b);
      logic [IW-1:0] w = b;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         int i = (int'(b) + k) % NUM_REQ;
         if (v[IW'(i)]) w = IW'(i);
      end
      return w;
   endfunction

`ifdef UART_TX_ARB_FIXED_PRIORITY_EN
   assign base = '0;
`else
   logic [IW-1:0] rr_ptr_q, rr_ptr_d;
   assign base = rr_ptr_q;
   // Pointer moves past the winner once the grant is committed; with one requester it stays 0.
   always_comb rr_ptr_d = state_q != LOAD ? rr_ptr_q : int'(grant_id_q) == NUM_REQ - 1 ? '0 : grant_id_q + 1'b1;
   always_ff @(posedge clk or posedge reset)
      if (reset) rr_ptr_q <= '0;
      else rr_ptr_q <= rr_ptr_d;
`endif

   assign win = pick(req_valid, base);

   always_comb begin
      state_d = state_q;
      req_ready_d = '0;
      tx_start_d = 1'b0;
      tx_data_d = tx_data_q;
      grant_id_d = grant_id_q;
      cnt_d = cnt_q;
      timeout_err_d = timeout_err_q;
      case (state_q)
         IDLE: if (!tx_busy && |req_valid) begin
            req_ready_d = NUM_REQ'(1) << win;
            tx_data_d = req_data[int'(win)*DATA_WIDTH +: DATA_WIDTH];
            grant_id_d = win;
            state_d = LOAD;
         end
         LOAD: state_d = START;
         START: begin
            tx_start_d = 1'b1;
            cnt_d = '0;
            state_d = WAIT_BUSY;
         end
         WAIT_BUSY: if (tx_busy) state_d = WAIT_DONE;
            else if (cnt_q == CW'(START_TIMEOUT - 1)) begin
               timeout_err_d = 1'b1;
               state_d = IDLE;
            end else cnt_d = cnt_q + 1'b1;
         WAIT_DONE: if (!tx_busy) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         state_q <= IDLE;
         req_ready_q <= '0;
         tx_start_q <= 1'b0;
         tx_data_q <= '0;
         grant_id_q <= '0;
         cnt_q <= '0;
         timeout_err_q <= 1'b0;
      end else begin
         state_q <= state_d;
         req_ready_q <= req_ready_d;
         tx_start_q <= tx_start_d;
         tx_data_q <= tx_data_d;
         grant_id_q <= grant_id_d;
         cnt_q <= cnt_d;
         timeout_err_q <= timeout_err_d;
      end

   assign req_ready = req_ready_q;
   assign tx_start = tx_start_q;
   assign tx_data = tx_data_q;
   assign grant_id = grant_id_q;
   assign arb_busy = state_q != IDLE;
   assign timeout_err = timeout_err_q;
endmodule
